// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the line memory and its clients.
//   - off_bits / idx_bits : derive the byte-offset and line-index field widths
//                           of a byte address from the line width and depth.
//   - mem_req_t / mem_resp_t : request/response bundles at the default build
//                           widths (32-bit PA, 128-bit line, 2-bit ID).
// Parametrised modules build their own packed types from their parameters;
// these typedefs describe the default configuration seen by the arbiter
// and cache.
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam int DEFAULT_PA_WIDTH   = 32;
  localparam int DEFAULT_LINE_WIDTH = 128;
  localparam int DEFAULT_ID_WIDTH   = 2;

  // Byte-offset bits inside one line (line_width is in bits).
  function automatic int off_bits(input int line_width);
    return $clog2(line_width / 8);
  endfunction

  // Line-index bits; kept at least 1 so slices stay legal.
  function automatic int idx_bits(input int num_lines);
    return (num_lines > 1) ? $clog2(num_lines) : 1;
  endfunction

  typedef struct packed {
    logic                          write;
    logic [DEFAULT_PA_WIDTH-1:0]   addr;
    logic [DEFAULT_LINE_WIDTH-1:0] data;
    logic [DEFAULT_ID_WIDTH-1:0]   id;
  } mem_req_t;

  typedef struct packed {
    logic [DEFAULT_LINE_WIDTH-1:0] data;
    logic [DEFAULT_ID_WIDTH-1:0]   id;
  } mem_resp_t;

endpackage

// File: rtl/resp_fifo.sv
// -----------------------------------------------------------------------------
// resp_fifo
// Show-ahead FIFO: the head entry is visible on head_data whenever empty is
// low, and pop consumes it. A push and a pop in the same cycle are legal even
// when full (the pop frees the slot the push fills).
// Ports:
//   clk, rst    clock, synchronous active-high reset (pointers and count only)
//   push        write push_data at the tail
//   push_data   WIDTH-bit entry to store
//   pop         consume the head entry (ignored when empty)
//   head_data   current head entry
//   full/empty  occupancy flags
//   count       number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module resp_fifo #(
  parameter int   WIDTH = 8,
  parameter int   DEPTH = 4,
  localparam int  CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would make results order-dependent.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is deliberately left out of reset; empty/count already mark
  // every entry invalid, and a reset on the array would block RAM inference.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/pipelined_line_memory.sv
// -----------------------------------------------------------------------------
// pipelined_line_memory
// Line-granular backing store with a fixed read latency and several reads in
// flight. Reads sample the store in the accept cycle, travel through a
// valid/data/ID shift pipeline and land in a show-ahead response FIFO.
// Request-side ready is a credit check: reads in the pipeline plus responses
// buffered in the FIFO may never exceed QUEUE_DEPTH, so the FIFO cannot
// overflow even with the cache stalled.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_mem_enable        request valid from the arbiter
//   i_mem_write         1 = write line, 0 = read line
//   i_mem_addr          byte address (offset and upper bits ignored)
//   i_mem_data          write line data
//   i_mem_id            requester ID, echoed with the read response
//   o_mem_ready         request accepted this cycle if i_mem_enable is high
//   o_mem_enable        response valid to the cache
//   o_mem_data          response line data (zero when no response)
//   o_mem_id_response   response ID (zero when no response)
//   i_resp_ready        cache consumes the response this cycle
// -----------------------------------------------------------------------------
module pipelined_line_memory
  import mem_pkg::*;
#(
  parameter int PA_WIDTH    = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int ID_WIDTH    = 2,
  parameter int NUM_LINES   = 256,
  parameter int LATENCY     = 4,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_enable,
  input  logic                  i_mem_write,
  input  logic [PA_WIDTH-1:0]   i_mem_addr,
  input  logic [LINE_WIDTH-1:0] i_mem_data,
  input  logic [ID_WIDTH-1:0]   i_mem_id,
  output logic                  o_mem_ready,
  output logic                  o_mem_enable,
  output logic [LINE_WIDTH-1:0] o_mem_data,
  output logic [ID_WIDTH-1:0]   o_mem_id_response,
  input  logic                  i_resp_ready
);

  localparam int OFF = off_bits(LINE_WIDTH);
  localparam int IDX = idx_bits(NUM_LINES);
  localparam int CW  = $clog2(QUEUE_DEPTH + 1);

  typedef struct packed {
    logic [LINE_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
  } resp_t;

  logic [LINE_WIDTH-1:0] store [NUM_LINES];
  logic [IDX-1:0]        line_idx;
  logic                  accept;
  logic                  rd_accept;
  logic                  wr_accept;
  resp_t                 sample;
  logic                  push_valid;
  resp_t                 push_resp;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           credits_used;
  logic                  fifo_full;
  logic                  fifo_empty;
  resp_t                 head;
  logic                  unused_bits;

  // Upper address bits fold onto the same lines (modulo NUM_LINES).
  assign line_idx  = i_mem_addr[OFF+IDX-1:OFF];

  // Requests presented while rst is high are dropped.
  assign accept    = i_mem_enable & o_mem_ready & ~rst;
  assign rd_accept = accept & ~i_mem_write;
  assign wr_accept = accept &  i_mem_write;

  // Written at the end of the accept cycle, so a read accepted one cycle
  // later already sees the new line.
  always_ff @(posedge clk) begin
    if (wr_accept) store[line_idx] <= i_mem_data;
  end

  assign sample = '{data: store[line_idx], id: i_mem_id};

  // Stage 0 is the combinational sample in the accept cycle; LATENCY-1
  // registered stages follow, and the last one pushes into the FIFO so the
  // response is visible LATENCY cycles after acceptance.
  if (LATENCY == 1) begin : g_no_stages
    assign push_valid = rd_accept;
    assign push_resp  = sample;
  end else begin : g_stages
    localparam int NS = LATENCY - 1;

    logic [NS-1:0] vld;
    resp_t         pl [NS];

    always_ff @(posedge clk) begin
      if (rst) begin
        vld <= '0;
      end else begin
        vld[0] <= rd_accept;
        for (int i = 1; i < NS; i++) vld[i] <= vld[i-1];
      end
    end

    // Payload shifts unconditionally; only the valid bits carry meaning.
    always_ff @(posedge clk) begin
      pl[0] <= sample;
      for (int i = 1; i < NS; i++) pl[i] <= pl[i-1];
    end

    assign push_valid = vld[NS-1];
    assign push_resp  = pl[NS-1];
  end

  // Reads between acceptance and FIFO push.
  always_ff @(posedge clk) begin
    if (rst) inflight <= '0;
    else     inflight <= inflight + CW'(rd_accept) - CW'(push_valid);
  end

  // Depends only on registered state, never on i_mem_enable. Writes are gated
  // too, keeping the handshake uniform for the arbiter.
  assign credits_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign o_mem_ready  = credits_used < (CW+1)'(QUEUE_DEPTH);

  resp_fifo #(
    .WIDTH ($bits(resp_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_valid),
    .push_data (push_resp),
    .pop       (o_mem_enable & i_resp_ready),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Outputs read zero while no response is pending so nothing stale leaks
  // out of the unreset FIFO storage.
  assign o_mem_enable      = ~fifo_empty;
  assign o_mem_data        = o_mem_enable ? head.data : '0;
  assign o_mem_id_response = o_mem_enable ? head.id   : '0;

  // Full never needs to be consulted: the credit check rules out overflow.
  assign unused_bits = ^{i_mem_addr, fifo_full};

endmodule
